// File: rtl/bank_ring_pkg.sv
// Width helpers and default sizing shared by the bank ring FIFO and its storage.
package bank_ring_pkg;

  function automatic int unsigned off_width(input int unsigned bank_depth);
    return $clog2(bank_depth);
  endfunction

  function automatic int unsigned bank_width(input int unsigned bank_count);
    return $clog2(bank_count);
  endfunction

  function automatic int unsigned len_width(input int unsigned bank_depth);
    return $clog2(bank_depth) + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned bank_count);
    return $clog2(bank_count) + 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned bank_depth,
                                             input int unsigned bank_count);
    return $clog2(bank_depth) + $clog2(bank_count);
  endfunction

  localparam int unsigned DEF_W          = 16;
  localparam int unsigned DEF_BANK_DEPTH = 128;
  localparam int unsigned DEF_BANK_COUNT = 2;
  localparam int unsigned DEF_OFF_W      = off_width(DEF_BANK_DEPTH);
  localparam int unsigned DEF_CNT_W      = cnt_width(DEF_BANK_COUNT);
  localparam int unsigned DEF_ADDR_W     = addr_width(DEF_BANK_DEPTH, DEF_BANK_COUNT);

endpackage

// File: rtl/bank_ring_mem.sv
// Simple dual-port RAM: one write port, one registered read port that holds when idle.
module bank_ring_mem
  import bank_ring_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/bank_ring_fifo.sv
// Bank-granular ring FIFO: writer fills banks and commits them, reader drains whole banks.
module bank_ring_fifo
  import bank_ring_pkg::*;
#(
  parameter int unsigned W          = DEF_W,
  parameter int unsigned BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int unsigned BANK_COUNT = DEF_BANK_COUNT
) (
  input  logic                                clk,
  input  logic                                rst_,
  input  logic                                w_trigger,
  input  logic [W-1:0]                        w_data,
  input  logic                                w_flush,
  output logic                                w_done,
  input  logic                                r_trigger,
  output logic [W-1:0]                        r_data,
  output logic                                r_done,
  output logic                                r_last,
  output logic [cnt_width(BANK_COUNT)-1:0]    count
);

  localparam int unsigned OFF_W  = off_width(BANK_DEPTH);
  localparam int unsigned BANK_W = bank_width(BANK_COUNT);
  localparam int unsigned LEN_W  = len_width(BANK_DEPTH);
  localparam int unsigned CNT_W  = cnt_width(BANK_COUNT);
  localparam int unsigned ADDR_W = addr_width(BANK_DEPTH, BANK_COUNT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BANK_COUNT);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BANK_DEPTH - 1);

  logic [BANK_W-1:0] wbank_q, wbank_d, rbank_q, rbank_d;
  logic [OFF_W-1:0]  woff_q, woff_d, roff_q, roff_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              r_done_q, r_done_d, r_last_q, r_last_d;
  logic              have_data_q, have_data_d;
  logic [LEN_W-1:0]  len_q [BANK_COUNT];

  logic              w_acc, r_acc, commit, free_bank, rd_is_last;
  logic [LEN_W-1:0]  commit_len;
  logic [W-1:0]      mem_rdata;

  always_comb begin
    // Writes are refused while reset is held so w_done stays low.
    w_acc      = rst_ && w_trigger && (count_q < CNT_FULL);
    r_acc      = r_trigger && (count_q != '0);
    rd_is_last = (({1'b0, roff_q} + LEN_W'(1)) == len_q[rbank_q]);
    commit     = (w_acc && (woff_q == OFF_LAST)) || (w_flush && (w_acc || (woff_q != '0)));
    commit_len = {1'b0, woff_q} + LEN_W'(w_acc);
    free_bank  = r_acc && rd_is_last;

    wbank_d     = wbank_q;
    woff_d      = woff_q;
    rbank_d     = rbank_q;
    roff_d      = roff_q;
    if (commit) begin
      wbank_d = wbank_q + 1'b1;
      woff_d  = '0;
    end else if (w_acc) begin
      woff_d  = woff_q + 1'b1;
    end
    if (free_bank) begin
      rbank_d = rbank_q + 1'b1;
      roff_d  = '0;
    end else if (r_acc) begin
      roff_d  = roff_q + 1'b1;
    end
    count_d     = count_q + CNT_W'(commit) - CNT_W'(free_bank);
    r_done_d    = r_acc;
    r_last_d    = free_bank;
    have_data_d = have_data_q | r_acc;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wbank_q     <= '0;
      woff_q      <= '0;
      rbank_q     <= '0;
      roff_q      <= '0;
      count_q     <= '0;
      r_done_q    <= 1'b0;
      r_last_q    <= 1'b0;
      have_data_q <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      woff_q      <= woff_d;
      rbank_q     <= rbank_d;
      roff_q      <= roff_d;
      count_q     <= count_d;
      r_done_q    <= r_done_d;
      r_last_q    <= r_last_d;
      have_data_q <= have_data_d;
    end
  end

  // Bank lengths live with the data: never reset, only meaningful once committed.
  always_ff @(posedge clk) begin
    if (commit) len_q[wbank_q] <= commit_len;
  end

  bank_ring_mem #(
    .W      (W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_acc),
    .waddr ({wbank_q, woff_q}),
    .wdata (w_data),
    .re    (r_acc),
    .raddr ({rbank_q, roff_q}),
    .rdata (mem_rdata)
  );

  // The RAM output register has no reset, so mask it until a read has landed.
  assign r_data = have_data_q ? mem_rdata : '0;
  assign w_done = w_acc;
  assign r_done = r_done_q;
  assign r_last = r_last_q;
  assign count  = count_q;

endmodule

// File: tb/tb_bank_ring_fifo.sv
// Randomized and directed bench for bank_ring_fifo against a queue-based bank model.
module tb_bank_ring_fifo;

  localparam int DEPTH = 4;
  localparam int NBANK = 2;

  logic        clk = 1'b0;
  logic        rst_;
  logic        w_trigger, w_flush, r_trigger;
  logic [15:0] w_data;
  logic        w_done, r_done, r_last;
  logic [15:0] r_data;
  logic [1:0]  count;

  bank_ring_fifo #(.W(16), .BANK_DEPTH(DEPTH), .BANK_COUNT(NBANK)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .w_trigger (w_trigger),
    .w_data    (w_data),
    .w_flush   (w_flush),
    .w_done    (w_done),
    .r_trigger (r_trigger),
    .r_data    (r_data),
    .r_done    (r_done),
    .r_last    (r_last),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: committed banks as a length list plus a flat word stream, and the open bank.
  int          lens[$];
  logic [15:0] words[$];
  logic [15:0] cur[$];
  int          rd_pos = 0;
  logic [15:0] held   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_clear();
    lens.delete();
    words.delete();
    cur.delete();
    rd_pos = 0;
    held   = '0;
  endtask

  task automatic step(input logic wt, input logic [15:0] wd, input logic wf, input logic rt);
    bit w_m, r_m, last_m;
    int sz;
    @(negedge clk);
    w_trigger = wt;
    w_data    = wd;
    w_flush   = wf;
    r_trigger = rt;
    #1;
    sz  = lens.size();
    w_m = wt && (sz < NBANK);
    r_m = rt && (sz > 0);
    chk("w_done", 32'(w_done), 32'(w_m));
    chk("count", 32'(count), 32'(sz));
    last_m = 1'b0;
    if (r_m) begin
      held   = words.pop_front();
      last_m = (rd_pos == lens[0] - 1);
      if (last_m) begin
        void'(lens.pop_front());
        rd_pos = 0;
      end else begin
        rd_pos++;
      end
    end
    if (w_m) cur.push_back(wd);
    if ((w_m && cur.size() == DEPTH) || (wf && cur.size() > 0)) begin
      lens.push_back(cur.size());
      foreach (cur[i]) words.push_back(cur[i]);
      cur.delete();
    end
    @(posedge clk);
    #1;
    chk("r_done", 32'(r_done), 32'(r_m));
    chk("r_last", 32'(r_last), 32'(last_m));
    chk("r_data", 32'(r_data), 32'(held));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_w_done"}, 32'(w_done), 32'(0));
    chk({tag, "_r_done"}, 32'(r_done), 32'(0));
    chk({tag, "_r_last"}, 32'(r_last), 32'(0));
    chk({tag, "_r_data"}, 32'(r_data), 32'(0));
    chk({tag, "_count"},  32'(count),  32'(0));
  endtask

  initial begin
    rst_      = 1'b0;
    w_trigger = 1'b1;
    w_data    = 16'hFFFF;
    w_flush   = 1'b1;
    r_trigger = 1'b1;
    #3;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    w_trigger = 1'b0;
    w_flush   = 1'b0;
    r_trigger = 1'b0;
    rst_      = 1'b1;

    // Fill both banks, then one refused write.
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'(2));
    step(1'b1, 16'h0009, 1'b0, 1'b0);
    // Drain with one extra read.
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, 1'b1);
    chk("drain_count", 32'(count), 32'(0));

    // Partial bank committed by a bare flush.
    step(1'b1, 16'h000A, 1'b0, 1'b0);
    step(1'b1, 16'h000B, 1'b0, 1'b0);
    step(1'b1, 16'h000C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'(1));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Flush together with a write, then flush of an empty bank.
    step(1'b1, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 16'h0012, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("empty_flush_count", 32'(count), 32'(1));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Commit of bank B in the cycle the last word of bank A is read.
    step(1'b1, 16'h0021, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b1, 1'b0);
    step(1'b1, 16'h0031, 1'b0, 1'b1);
    step(1'b1, 16'h0032, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 1'b0, 1'b0);
    step(1'b1, 16'h0034, 1'b0, 1'b1);
    chk("swap_count", 32'(count), 32'(1));
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Reset mid-burst.
    step(1'b1, 16'h0041, 1'b0, 1'b0);
    step(1'b1, 16'h0042, 1'b0, 1'b0);
    step(1'b1, 16'h0043, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    w_trigger = 1'b1;
    r_trigger = 1'b1;
    rst_      = 1'b0;
    #1;
    check_reset_outputs("rst1");
    model_clear();
    @(negedge clk);
    w_trigger = 1'b0;
    r_trigger = 1'b0;
    rst_      = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
